// File: rtl/mcpu_datapath_pkg.sv
// Shared definitions for the multicycle CPU datapath: opcode/func values,
// control-select encodings and the jal link register.
package mcpu_datapath_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FUNC_ADD = 6'b100000;
  localparam logic [5:0] FUNC_SUB = 6'b100010;
  localparam logic [5:0] FUNC_AND = 6'b100100;
  localparam logic [5:0] FUNC_OR  = 6'b100101;
  localparam logic [5:0] FUNC_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ALUOP_ADD  = 2'b00,
    ALUOP_SUB  = 2'b01,
    ALUOP_FUNC = 2'b10,
    ALUOP_RSVD = 2'b11
  } aluop_e;

  typedef enum logic [1:0] {
    ALUB_REG     = 2'b00,
    ALUB_FOUR    = 2'b01,
    ALUB_IMM     = 2'b10,
    ALUB_IMM_SH2 = 2'b11
  } aluselb_e;

  typedef enum logic [1:0] {
    PCS_ALU    = 2'b00,
    PCS_ALUOUT = 2'b01,
    PCS_JUMP   = 2'b10,
    PCS_REG    = 2'b11
  } pcs_e;

  localparam logic [4:0] LINK_REG = 5'd31;

  function automatic logic [31:0] signExt16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mcpu_datapath_if.sv
// Control-unit / memory side of the datapath: strobes and selects in,
// instruction fields and memory bus out.
interface mcpu_datapath_if;

  logic        pcw, pcwc, iord, mr, mw, irw, regw, mtor, rdst, alusela, tw;
  logic [1:0]  aluselb, aluop, pcs;
  logic [5:0]  op, func;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, dbg_pc;
  logic        mem_rd, mem_wr;

  modport master (
    output pcw, pcwc, iord, mr, mw, irw, regw, mtor, rdst, alusela, tw,
    output aluselb, aluop, pcs, mem_rdata,
    input  op, func, mem_addr, mem_wdata, mem_rd, mem_wr, dbg_pc
  );

  modport slave (
    input  pcw, pcwc, iord, mr, mw, irw, regw, mtor, rdst, alusela, tw,
    input  aluselb, aluop, pcs, mem_rdata,
    output op, func, mem_addr, mem_wdata, mem_rd, mem_wr, dbg_pc
  );

endinterface

// File: rtl/mcpu_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port, synchronous reset; $0 is hardwired to zero.
module mcpu_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write is not bypassed.
  assign rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : regs_q[raddr2_i];

endmodule

// File: rtl/mcpu_datapath.sv
// Multicycle MIPS-style datapath: PC, IR, MDR, A, B, ALUOut, register file
// and ALU, steered cycle by cycle by an external control unit.
module mcpu_datapath
  import mcpu_datapath_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  mcpu_datapath_if.slave bus
);

  logic [31:0] pc_q, pc_d, ir_q, ir_d, mdr_q, mdr_d;
  logic [31:0] a_q, a_d, b_q, b_d, aluOut_q, aluOut_d;
  logic [31:0] rfRdata1, rfRdata2, rfWdata;
  logic [4:0]  rfWaddr;
  logic [31:0] immExt, aluA, aluB, aluResult, pcNext;
  logic        aluZero, branchTaken, pcLoad;

  assign immExt = signExt16(ir_q[15:0]);

  always_comb begin
    aluA = bus.alusela ? a_q : pc_q;
    case (bus.aluselb)
      ALUB_REG:  aluB = b_q;
      ALUB_FOUR: aluB = 32'd4;
      ALUB_IMM:  aluB = immExt;
      default:   aluB = immExt << 2;
    endcase
    aluResult = aluA + aluB;
    case (bus.aluop)
      ALUOP_SUB:  aluResult = aluA - aluB;
      ALUOP_FUNC: begin
        case (ir_q[5:0])
          FUNC_SUB: aluResult = aluA - aluB;
          FUNC_AND: aluResult = aluA & aluB;
          FUNC_OR:  aluResult = aluA | aluB;
          FUNC_SLT: aluResult = ($signed(aluA) < $signed(aluB)) ? 32'd1 : 32'd0;
          default:  aluResult = aluA + aluB;
        endcase
      end
      default:    aluResult = aluA + aluB;
    endcase
  end

  // BNE inverts the sense of the zero flag; every other branch opcode is BEQ.
  assign aluZero     = (aluResult == 32'd0);
  assign branchTaken = aluZero ^ (ir_q[31:26] == OP_BNE);
  assign pcLoad      = bus.pcw | (bus.pcwc & branchTaken);

  always_comb begin
    case (bus.pcs)
      PCS_ALU:    pcNext = aluResult;
      PCS_ALUOUT: pcNext = aluOut_q;
      PCS_JUMP:   pcNext = {pc_q[31:28], ir_q[25:0], 2'b00};
      default:    pcNext = a_q;
    endcase
  end

  always_comb begin
    rfWaddr = bus.rdst ? ir_q[15:11] : ir_q[20:16];
    rfWdata = bus.mtor ? mdr_q : aluOut_q;
    if (bus.tw) begin
      rfWaddr = LINK_REG;
      rfWdata = pc_q;
    end
  end

  mcpu_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .raddr1_i (ir_q[25:21]),
    .raddr2_i (ir_q[20:16]),
    .rdata1_o (rfRdata1),
    .rdata2_o (rfRdata2),
    .we_i     (bus.regw & ~rst),
    .waddr_i  (rfWaddr),
    .wdata_i  (rfWdata)
  );

  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    mdr_d    = mem_rdataOrZero();
    a_d      = rfRdata1;
    b_d      = rfRdata2;
    aluOut_d = aluResult;
    if (pcLoad)  pc_d = pcNext;
    if (bus.irw) ir_d = bus.mem_rdata;
    if (rst) begin
      pc_d     = '0;
      ir_d     = '0;
      mdr_d    = '0;
      a_d      = '0;
      b_d      = '0;
      aluOut_d = '0;
    end
  end

  function automatic logic [31:0] mem_rdataOrZero();
    return bus.mem_rdata;
  endfunction

  always_ff @(posedge clk) begin
    pc_q     <= pc_d;
    ir_q     <= ir_d;
    mdr_q    <= mdr_d;
    a_q      <= a_d;
    b_q      <= b_d;
    aluOut_q <= aluOut_d;
  end

  // Outputs are forced to zero while reset is held, before state has cleared.
  assign bus.op        = rst ? 6'd0  : ir_q[31:26];
  assign bus.func      = rst ? 6'd0  : ir_q[5:0];
  assign bus.mem_addr  = rst ? 32'd0 : (bus.iord ? aluOut_q : pc_q);
  assign bus.dbg_pc    = rst ? 32'd0 : pc_q;
  assign bus.mem_wdata = b_q;
  assign bus.mem_rd    = bus.mr;
  assign bus.mem_wr    = bus.mw;

endmodule

// File: doc/mcpu_datapath.md
MCPU_DATAPATH -- requirements
Module: mcpu_datapath

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 pcw, pcwc, iord, mr, mw, irw, regw, mtor, rdst, alusela, tw  in  1 each  control strobes from the multicycle control unit.
REQ-004 aluselb, aluop, pcs  in  2 each  control selects from the control unit.
REQ-005 op  out  6  IR[31:26]; func  out  6  IR[5:0]; both go back to the control unit.
REQ-006 mem_addr  out  32  byte address: PC when iord=0, ALUOut when iord=1.
REQ-007 mem_wdata  out  32  register B; mem_rd  out  1  equals mr; mem_wr  out  1  equals mw.
REQ-008 mem_rdata  in  32  memory read data, combinationally valid in the same cycle as mem_rd.
REQ-009 dbg_pc  out  32  current PC value.

Function
REQ-010 The block holds these registers: PC, IR, MDR, A, B, ALUOut, plus the 32x32 register file.
REQ-011 IR loads mem_rdata only when irw=1.
REQ-012 MDR, A, B and ALUOut load every cycle: MDR<=mem_rdata, A<=rf[IR[25:21]], B<=rf[IR[20:16]], ALUOut<=ALU result.
REQ-013 ALU operand A is selected by alusela: 0=PC, 1=A.
REQ-014 ALU operand B is selected by aluselb: 00=B, 01=32'd4, 10=signext(IR[15:0]), 11=signext(IR[15:0])<<2.
REQ-015 aluop encoding: 00=add, 01=sub, 10=decode func, 11=reserved (treated as add).
REQ-016 func decode: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed, result 0/1); any other func gives add.
REQ-017 All arithmetic is 32-bit two's-complement with wrap-around; no overflow trap; zero = (ALU result == 0).
REQ-018 PC next-value mux by pcs: 00=ALU result, 01=ALUOut, 10={PC[31:28],IR[25:0],2'b00}, 11=A (jr).
REQ-019 PC loads when pcw=1, or when pcwc=1 and branch taken.
REQ-020 Branch taken = zero XOR (op==6'b000101); BEQ takes on zero, BNE takes on nonzero.
REQ-021 When pcw and pcwc are both 1, pcw governs and PC loads unconditionally.
REQ-022 Register-file write occurs only when regw=1.
REQ-023 Write address selection: tw=1 gives 31; otherwise rdst=1 gives IR[15:11] and rdst=0 gives IR[20:16].
REQ-024 Write data selection: tw=1 gives PC (the jal link); otherwise mtor=1 gives MDR and mtor=0 gives ALUOut.
REQ-025 Register $0 reads as 0, and writes to it are discarded.
REQ-026 A write and a read of the same register in the same cycle return the old value (no bypass).
REQ-027 mw=1 and mr=1 together are illegal; the datapath drives both strobes unchanged and gives no precedence.

Reset
REQ-028 While rst=1, PC, IR, MDR, A, B, ALUOut and all 32 registers load 0, and the control inputs are ignored.
REQ-029 A reset asserted mid-instruction discards all in-flight state; the first cycle after rst deasserts fetches from address 0.
REQ-030 During reset: op=0, func=0, mem_addr=0 (or ALUOut=0), dbg_pc=0.

Structure
REQ-031 The shared package holds: opcode constants, func constants, aluop/aluselb/pcs encodings, and the constant 5'd31 link register.
REQ-032 The register file is a single sub-module, mcpu_regfile: 2 asynchronous read ports, 1 synchronous write port, synchronous reset.
REQ-033 The ALU stays in mcpu_datapath as combinational logic; no other sub-modules.

Verification
REQ-034 Fetch: rst, then one cycle of mr=1, irw=1, aluselb=01, pcw=1 with mem_rdata=0x8C220004 -> PC=4, op=100011, mem_addr=0 during the cycle.
REQ-035 R-type add: rf[1]=5, rf[2]=7, IR=0x00221820; drive alusela=1, aluop=10, then regw=1, rdst=1 -> rf[3]=12.
REQ-036 BNE: rf[1]=rf[2]=3, pcwc=1, pcs=01, aluop=01 with opcode 000101 -> PC unchanged. Same with rf[2]=4 -> PC=ALUOut.
REQ-037 jal: IR=0x0C000010, PC=8; drive pcw=1, pcs=10, regw=1, tw=1 -> rf[31]=8, PC=0x40.
REQ-038 Reset mid-instruction: assert rst during a lw sequence -> all registers 0 the next cycle and mem_addr=0.
REQ-039 $0 protection: regw=1 with write address 0 and data 0xFFFFFFFF -> A reads 0 next cycle. slt with -1 vs 1 -> 1.
